// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared state encoding and constants for the pipeline sequencer
package hazard_stall_controller_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: hazard inputs from the pipeline and the resulting stage controls
interface hazard_stall_controller_if #(
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
);
   logic                   in_IdEx_MemRead;
   logic [4:0]             in_IdEx_RegisterRt;
   logic [4:0]             in_IfId_RegisterRs;
   logic [4:0]             in_IfId_RegisterRt;
   logic                   in_IfId_UsesRt;
   logic                   in_BranchTaken;
   logic                   in_DMem_Req;
   logic                   in_DMem_Ready;
   logic                   in_PerfClr;
   logic                   PC_Write;
   logic                   IfId_Write;
   logic                   IfId_Flush;
   logic                   IdEx_Bubble;
   logic                   Pipe_Freeze;
   logic                   Mem_Error;
   logic [STALL_CNT_W-1:0] Stall_Count;
   logic [FLUSH_CNT_W-1:0] Flush_Count;
   modport master (
      output in_IdEx_MemRead, in_IdEx_RegisterRt, in_IfId_RegisterRs, in_IfId_RegisterRt,
             in_IfId_UsesRt, in_BranchTaken, in_DMem_Req, in_DMem_Ready, in_PerfClr,
      input  PC_Write, IfId_Write, IfId_Flush, IdEx_Bubble, Pipe_Freeze, Mem_Error,
             Stall_Count, Flush_Count
   );
   modport slave (
      input  in_IdEx_MemRead, in_IdEx_RegisterRt, in_IfId_RegisterRs, in_IfId_RegisterRt,
             in_IfId_UsesRt, in_BranchTaken, in_DMem_Req, in_DMem_Ready, in_PerfClr,
      output PC_Write, IfId_Write, IfId_Flush, IdEx_Bubble, Pipe_Freeze, Mem_Error,
             Stall_Count, Flush_Count
   );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// hazard_stall_controller_sat_counter: saturating event counter with synchronous clear
module hazard_stall_controller_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   // clear wins over increment; the count sticks at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset)
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && count != '1)
         count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: stall, bubble, flush and freeze sequencing for the 5-stage pipeline
module hazard_stall_controller
   import hazard_stall_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
) (
   input logic                      clk,
   input logic                      reset,
   hazard_stall_controller_if.slave hz
);
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
   state_t     state, stateNext;
   logic [7:0] waitCnt, waitCntNext;
   logic       memStall, loadUse, freeze, stall, flush;
   assign memStall = hz.in_DMem_Req & ~hz.in_DMem_Ready;
   assign loadUse  = hz.in_IdEx_MemRead & (hz.in_IdEx_RegisterRt != REG_ZERO) &
                     ((hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRs) |
                      (hz.in_IfId_UsesRt & (hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRt)));
   // waitCnt counts consecutive stalled memory cycles, the entry cycle included; the cycle that
   // brings it to MEM_TIMEOUT moves to ERROR. A freeze masks load-use and branch, and the
   // LU_STALL cycle masks load-use because the bubble already sits in EX.
   always_comb begin
      stateNext   = RUN;
      waitCntNext = '0;
      freeze      = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      if (state == ERROR) begin
         stateNext = ERROR;
         freeze    = 1'b1;
      end else if (memStall) begin
         freeze      = 1'b1;
         waitCntNext = (state == MEM_WAIT) ? waitCnt + 8'd1 : 8'd1;
         stateNext   = (waitCntNext == TIMEOUT) ? ERROR : MEM_WAIT;
      end else if (loadUse && state != LU_STALL) begin
         stall     = 1'b1;
         stateNext = LU_STALL;
      end else
         flush = hz.in_BranchTaken;
   end
   // sequencer state and memory wait counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= RUN;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
      end
   assign hz.PC_Write    = ~(freeze | stall);
   assign hz.IfId_Write  = ~(freeze | stall);
   assign hz.IfId_Flush  = flush;
   assign hz.IdEx_Bubble = stall;
   assign hz.Pipe_Freeze = freeze;
   assign hz.Mem_Error   = (state == ERROR);
   hazard_stall_controller_sat_counter #(.WIDTH(STALL_CNT_W)) stallCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (freeze | stall),
      .clr   (hz.in_PerfClr),
      .count (hz.Stall_Count)
   );
   hazard_stall_controller_sat_counter #(.WIDTH(FLUSH_CNT_W)) flushCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .clr   (hz.in_PerfClr),
      .count (hz.Flush_Count)
   );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard bench with a cycle-level reference model of the sequencer
module tb_hazard_stall_controller;
   localparam int TO = 4;
   localparam int SW = 8;
   localparam int FW = 2;

   typedef struct {
      logic [4:0] ctl;
      logic       err;
      int         sc;
      int         fc;
      int         id;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   exp_t expQ[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   nStep = 0;

   int   mWaits = 0;
   bit   mErr = 0;
   bit   mBubbled = 0;
   int   mSc = 0;
   int   mFc = 0;

   hazard_stall_controller_if #(.STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) hz ();

   hazard_stall_controller #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // one clock of stimulus; expected outputs for this cycle come from the model's view of the
   // rules: a memory stall or a prior timeout freezes, else a load-use hazard stalls once, else a
   // taken branch flushes
   task automatic step(input bit rd, input logic [4:0] exRt, input logic [4:0] rs,
                       input logic [4:0] rt, input bit uses, input bit br, input bit req,
                       input bit rdy, input bit clr, input bit rst);
      exp_t x;
      bit ms, lu, fr, st, fl;
      @(posedge clk);
      #1;
      reset                 = rst;
      hz.in_IdEx_MemRead    = rd;
      hz.in_IdEx_RegisterRt = exRt;
      hz.in_IfId_RegisterRs = rs;
      hz.in_IfId_RegisterRt = rt;
      hz.in_IfId_UsesRt     = uses;
      hz.in_BranchTaken     = br;
      hz.in_DMem_Req        = req;
      hz.in_DMem_Ready      = rdy;
      hz.in_PerfClr         = clr;
      if (rst) begin
         mWaits = 0; mErr = 0; mBubbled = 0; mSc = 0; mFc = 0;
      end
      ms = req && !rdy;
      lu = rd && exRt != 5'd0 && (exRt == rs || (uses && exRt == rt));
      fr = mErr || ms;
      st = !fr && lu && !mBubbled;
      fl = !fr && !st && br;
      x.ctl = {!(fr || st), !(fr || st), fl, st, fr};
      x.err = mErr;
      x.sc  = mSc;
      x.fc  = mFc;
      x.id  = nStep;
      nStep++;
      expQ.push_back(x);
      if (!rst) begin
         if (!mErr) begin
            mWaits = ms ? mWaits + 1 : 0;
            if (mWaits >= TO) mErr = 1;
         end
         mBubbled = st;
         mSc = clr ? 0 : (fr || st) ? sat(mSc + 1, (1 << SW) - 1) : mSc;
         mFc = clr ? 0 : fl ? sat(mFc + 1, (1 << FW) - 1) : mFc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // monitor: every cycle the DUT presents its controls; pop the expectation and compare
   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            total++;
            if ({hz.PC_Write, hz.IfId_Write, hz.IfId_Flush, hz.IdEx_Bubble, hz.Pipe_Freeze,
                 hz.Mem_Error} !== {e.ctl, e.err}) begin
               bad++;
               $display("FAIL ctl step=%0d got pcw/ifw/flush/bubble/freeze/err=%b want=%b", e.id,
                        {hz.PC_Write, hz.IfId_Write, hz.IfId_Flush, hz.IdEx_Bubble,
                         hz.Pipe_Freeze, hz.Mem_Error}, {e.ctl, e.err});
            end
            total++;
            if (int'(hz.Stall_Count) != e.sc) begin
               bad++;
               $display("FAIL stall_count step=%0d got=%0d want=%0d", e.id, hz.Stall_Count, e.sc);
            end
            total++;
            if (int'(hz.Flush_Count) != e.fc) begin
               bad++;
               $display("FAIL flush_count step=%0d got=%0d want=%0d", e.id, hz.Flush_Count, e.fc);
            end
         end
      end
   end

   initial begin
      int rdyBias;
      hz.in_IdEx_MemRead = 0; hz.in_IdEx_RegisterRt = 0; hz.in_IfId_RegisterRs = 0;
      hz.in_IfId_RegisterRt = 0; hz.in_IfId_UsesRt = 0; hz.in_BranchTaken = 0;
      hz.in_DMem_Req = 0; hz.in_DMem_Ready = 0; hz.in_PerfClr = 0;
      reset = 1'b1;
      doReset();
      doReset();
      idle(1);
      // lw $5 in EX, ID reads rs=$5: one stall cycle, then defaults with Stall_Count=1
      step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // $0 destination and an rt match without UsesRt never stall
      doReset();
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(1, 7, 1, 7, 0, 0, 0, 0, 0, 0);
      step(1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
      idle(2);
      // three wait cycles then ready; ready without request is ignored
      doReset();
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
      // held stall reaches the timeout; error is sticky through ready until reset
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      doReset();
      idle(1);
      // load-use with a branch stalls only; the re-presented branch then flushes
      step(1, 9, 9, 0, 0, 1, 0, 0, 0, 0);
      step(1, 9, 9, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      // reset in the middle of a memory wait
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      doReset();
      idle(1);
      // flush counter saturation, then clear beating a concurrent flush
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      idle(2);
      // randomized traffic with phases of slow and fast memory
      rdyBias = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 60 == 0) rdyBias = $urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) ? 4 : 7);
         if ($urandom_range(0, 119) == 0) doReset();
         else
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) < rdyBias, $urandom_range(0, 49) == 0, 0);
      end
      idle(1);
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Decides each cycle whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, bubble or flush.
- Sources of those decisions: load-use hazards, taken branches/jumps resolved in ID, and a multi-cycle data memory with a req/ready handshake.
- Sits beside the forwarding unit and covers every hazard forwarding cannot resolve. It also keeps stall and flush performance counters and a memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 64, consecutive wait cycles in MEM_WAIT that trigger ERROR (legal range 2..255)
STALL_CNT_W, 32, width of the stall-cycle counter
FLUSH_CNT_W, 16, width of the flush counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
in_IdEx_MemRead  in  1  instruction in EX is a load
in_IdEx_RegisterRt  in  5  load destination register in EX
in_IfId_RegisterRs  in  5  rs of instruction in ID
in_IfId_RegisterRt  in  5  rt of instruction in ID
in_IfId_UsesRt  in  1  ID instruction reads rt (R-type, store, beq/bne)
in_BranchTaken  in  1  branch taken or jump decoded in ID this cycle
in_DMem_Req  in  1  MEM-stage access active
in_DMem_Ready  in  1  data memory completes the access this cycle
in_PerfClr  in  1  synchronous clear of both counters
PC_Write  out  1  PC may update
IfId_Write  out  1  IF/ID may load
IfId_Flush  out  1  IF/ID loads a NOP
IdEx_Bubble  out  1  ID/EX loads zeroed control
Pipe_Freeze  out  1  ID/EX, EX/MEM hold; MEM/WB loads bubble
Mem_Error  out  1  sticky timeout flag
Stall_Count  out  STALL_CNT_W  cycles in which PC_Write=0, saturating
Flush_Count  out  FLUSH_CNT_W  cycles in which IfId_Flush=1, saturating

Behaviour:
- Reset (async, immediate): state RUN, wait counter 0, both counters 0, Mem_Error 0.
- Reset values of the combinational outputs: PC_Write=1, IfId_Write=1, IfId_Flush=0, IdEx_Bubble=0, Pipe_Freeze=0.
- Control outputs are combinational from state and current inputs, so they take effect at the same clock edge. State and counters update on the rising clk edge.
- mem_stall = in_DMem_Req & ~in_DMem_Ready.
- load_use = in_IdEx_MemRead & (in_IdEx_RegisterRt != 0) & ((in_IdEx_RegisterRt == in_IfId_RegisterRs) | (in_IfId_UsesRt & (in_IdEx_RegisterRt == in_IfId_RegisterRt))).
- States: RUN, LU_STALL, MEM_WAIT, ERROR.
- RUN, priority order:
  - mem_stall: Pipe_Freeze=1, PC_Write=0, IfId_Write=0. Go to MEM_WAIT with wait counter=1.
  - else load_use: PC_Write=0, IfId_Write=0, IdEx_Bubble=1. Go to LU_STALL.
  - else in_BranchTaken: IfId_Flush=1. Stay in RUN.
  - else all outputs at default.
- LU_STALL, exactly one cycle:
  - load_use is suppressed, because the bubble now occupies EX.
  - mem_stall is handled as in RUN.
  - otherwise in_BranchTaken is handled as in RUN, then go to RUN.
- MEM_WAIT:
  - While mem_stall: freeze outputs stay asserted and the wait counter increments.
  - in_DMem_Ready=1 in this state releases the freeze in the same cycle (pipeline advances) and returns to RUN. load_use and branch are evaluated normally in that cycle.
  - If the wait counter == MEM_TIMEOUT while still stalled, go to ERROR.
  - in_BranchTaken is ignored during freeze; ID is held, so it re-presents the branch after release.
- ERROR: freeze outputs permanently asserted and Mem_Error=1. Only reset exits this state.
- Simultaneous events:
  - load_use + branch: stall only, no flush (branch re-evaluated next cycle).
  - mem_stall + anything: freeze only.
  - in_DMem_Req=0 with in_DMem_Ready=1: the ready is ignored.
- Counters:
  - Stall_Count increments in every cycle with PC_Write=0, including ERROR.
  - Flush_Count increments in every cycle with IfId_Flush=1.
  - Both saturate at all-ones; no wrap.
  - in_PerfClr zeroes both counters and takes priority over the increment in that cycle.
- Reset mid-MEM_WAIT: immediate return to RUN; the outstanding memory access is the memory's concern.

Decomposition:
- Shared package: state encoding (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2, ERROR=2'd3) and the register-zero constant 5'd0.
- One sub-module: sat_counter (parameterised width, inc, clr, count), instantiated twice for the counters.

Test Plan:
- lw $5 in EX (MemRead=1, Rt=5), ID reads Rs=5 -> one cycle of PC_Write=0, IdEx_Bubble=1; next cycle all defaults; Stall_Count=1.
- Same hazard with Rt=0 or UsesRt=0 and Rt match only -> no stall; Stall_Count stays 0.
- Req=1, Ready=0 for 3 cycles, then Ready=1 -> Pipe_Freeze high for 3 cycles, low on the ready cycle; Stall_Count=3; state returns to RUN.
- MEM_TIMEOUT=4, Req=1 and Ready=0 held -> Mem_Error=1 after the 4th wait cycle and remains set even when Ready later rises; reset clears it.
- load_use and BranchTaken in the same cycle -> IfId_Flush=0, stall asserted; BranchTaken next cycle -> IfId_Flush=1, Flush_Count=1.
- FLUSH_CNT_W=2, 5 flush cycles -> Flush_Count saturates at 3; PerfClr with a concurrent flush -> 0.
